crack_result_display: RTL and testbench
=======================================

Name: crack_result_display

Overview:
- Controller sitting directly downstream of the dual ARC4 key-cracking engine.
- Launches a crack run through the engine's en/rdy handshake and captures the returned key and key_valid.
- Drives the six 7-segment displays: blank when idle, a spinner animation while cracking, then the recovered key in hex, or dashes if no key was found.
- Counts elapsed run time in seconds and shows it on LEDR.

Parameters:
- SPIN_DIV, 22, width of the spinner prescaler; the spinner advances once every 2^SPIN_DIV cycles.
- TICK_CYCLES, 50000000, clk cycles per elapsed-time second.
- SEC_W, 10, width of the elapsed-seconds counter (≤10).

Ports:
- clk  in  1  system clock (CLOCK_50).
- rst_n  in  1  reset.
- start  in  1  run request; level sampled each cycle.
- crk_rdy  in  1  cracking engine ready.
- crk_en  out  1  cracking engine enable, one-cycle pulse.
- key  in  24  key from the engine; meaningful when crk_rdy rises after a run.
- key_valid  in  1  engine found a key.
- busy  out  1  run in progress.
- HEX0..HEX5  out  7 each  active-low segments, bit0=a … bit6=g; HEX5 is the most-significant nibble.
- LEDR  out  10  elapsed seconds, zero-extended from SEC_W.

Behaviour:
- Reset is synchronous, active-low: rst_n, clock clk.
- Reset values:
  - state IDLE; crk_en=0; busy=0; LEDR=0.
  - HEX0..5=7'h7F (blank).
  - Latched key and valid = 0; prescaler, spin index and seconds counters = 0.
- Reset asserted mid-run returns to IDLE immediately. The engine's own reset is shared, so no handshake cleanup is needed.
- States IDLE, LAUNCH, RUN, SHOW.
- IDLE:
  - HEX blank.
  - start=1 → LAUNCH.
- LAUNCH:
  - crk_en = crk_rdy (combinational).
  - If crk_rdy=1 → RUN. Also clear the prescaler, spin index and seconds counters.
  - Otherwise stay in LAUNCH with crk_en=0.
- RUN:
  - busy=1 (busy is also 1 in LAUNCH).
  - crk_rdy is ignored on the first RUN cycle, because the engine drops rdy one cycle after sampling en.
  - From the second cycle on, crk_rdy=1 latches key and key_valid, then → SHOW.
  - start is ignored in RUN.
- Spinner (RUN only):
  - SPIN_DIV-bit prescaler free-runs.
  - On wrap, spin index advances 0→1→…→5→0.
  - All six HEX digits light only segment [index] (a,b,c,d,e,f). Example: index 0 → 7'b1111110.
- Seconds counter (RUN only):
  - Cycle counter counts 0..TICK_CYCLES-1.
  - On wrap, seconds increments, saturating at 2^SEC_W-1 (no wrap-around).
  - The counter holds in SHOW and IDLE.
- SHOW:
  - If the latched valid=1: HEXn = hex glyph of key[4n+3:4n], using standard glyphs for 0-F. Example: 0=7'h40, A=7'h08, F=7'h0E.
  - If valid=0: all HEX = 7'h3F (dash).
  - LEDR keeps the final seconds value.
  - start=1 → LAUNCH, which starts a new run and clears seconds.
- Output timing:
  - HEX and LEDR are registered and reflect the state/data of the previous cycle (1-cycle latency).
  - crk_en and busy are combinational from state.
- crk_en is never high outside LAUNCH and is never high for two consecutive cycles.
- If start and crk_rdy are both high in IDLE, the transition goes to LAUNCH only; en is issued the next cycle at the earliest.

Test Plan:
- Reset, then idle 20 cycles → HEX0..5=7'h7F, LEDR=0, crk_en=0, busy=0.
- Bench uses TICK_CYCLES=10, SPIN_DIV=2; engine model rdy=1, start pulsed → crk_en one-cycle pulse in LAUNCH. The model drops rdy, holds it low 95 cycles, then raises it with key=24'h1A2B3C, key_valid=1. Required: SHOW reached; HEX5..HEX0 = glyphs 1,A,2,B,3,C; LEDR=9 (±1).
- Same run with key_valid=0 → all HEX=7'h3F; the latched key is not displayed.
- During RUN with SPIN_DIV=2, sample HEX every 4 cycles → segment index steps 0,1,2,3,4,5,0. All six digits are identical each sample.
- Engine holds rdy=0 for 20000 cycles with TICK_CYCLES=10 → LEDR saturates at 1023 and does not wrap.
- start held high through RUN → no second crk_en. In SHOW, start → new LAUNCH, LEDR clears to 0 and HEX shows the spinner. Reset asserted mid-RUN → IDLE with blank HEX next cycle.

Source files
------------

// File: rtl/crack_result_display.sv
// Launches an ARC4 crack run over en/rdy, shows a spinner while it runs, then the key (or dashes) on HEX5..HEX0.
// HEX/LEDR are registered (1-cycle latency); crk_en/busy are combinational from state; crk_en waits for crk_rdy.
module crack_result_display #(
    parameter int SPIN_DIV    = 22,
    parameter int TICK_CYCLES = 50000000,
    parameter int SEC_W       = 10
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        start,
    input  logic        crk_rdy,
    output logic        crk_en,
    input  logic [23:0] key,
    input  logic        key_valid,
    output logic        busy,
    output logic [6:0]  HEX0,
    output logic [6:0]  HEX1,
    output logic [6:0]  HEX2,
    output logic [6:0]  HEX3,
    output logic [6:0]  HEX4,
    output logic [6:0]  HEX5,
    output logic [9:0]  LEDR
);
    localparam int TICK_W = (TICK_CYCLES > 1) ? $clog2(TICK_CYCLES) : 1;

    typedef enum logic [1:0] {IDLE, LAUNCH, RUN, SHOW} state_t;

    state_t              state, state_nxt;
    logic                first_cyc;
    logic [SPIN_DIV-1:0] pre;
    logic [2:0]          spin_idx;
    logic [TICK_W-1:0]   tick_cnt;
    logic [SEC_W-1:0]    secs;
    logic [23:0]         key_q;
    logic                valid_q;
    logic [6:0]          hex_q   [6];
    logic [6:0]          hex_nxt [6];
    logic [9:0]          ledr_q;
    logic                launch_go;
    logic                run_done;

    function automatic logic [6:0] hex_glyph(input logic [3:0] nib);
        case (nib)
            4'h0:    hex_glyph = 7'h40;
            4'h1:    hex_glyph = 7'h79;
            4'h2:    hex_glyph = 7'h24;
            4'h3:    hex_glyph = 7'h30;
            4'h4:    hex_glyph = 7'h19;
            4'h5:    hex_glyph = 7'h12;
            4'h6:    hex_glyph = 7'h02;
            4'h7:    hex_glyph = 7'h78;
            4'h8:    hex_glyph = 7'h00;
            4'h9:    hex_glyph = 7'h10;
            4'hA:    hex_glyph = 7'h08;
            4'hB:    hex_glyph = 7'h03;
            4'hC:    hex_glyph = 7'h46;
            4'hD:    hex_glyph = 7'h21;
            4'hE:    hex_glyph = 7'h06;
            default: hex_glyph = 7'h0E;
        endcase
    endfunction

    assign launch_go = (state == LAUNCH) && crk_rdy;
    // The engine still shows rdy on the first RUN cycle, so completion is only trusted afterwards.
    assign run_done  = (state == RUN) && !first_cyc && crk_rdy;

    always_comb begin
        state_nxt = state;
        crk_en    = 1'b0;
        busy      = 1'b0;
        case (state)
            IDLE:   if (start) state_nxt = LAUNCH;
            LAUNCH: begin
                busy   = 1'b1;
                crk_en = crk_rdy;
                if (crk_rdy) state_nxt = RUN;
            end
            RUN: begin
                busy = 1'b1;
                if (run_done) state_nxt = SHOW;
            end
            SHOW:   if (start) state_nxt = LAUNCH;
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state     <= IDLE;
            first_cyc <= 1'b0;
            key_q     <= '0;
            valid_q   <= 1'b0;
        end else begin
            state     <= state_nxt;
            first_cyc <= launch_go;
            if (run_done) begin
                key_q   <= key;
                valid_q <= key_valid;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n || launch_go) begin
            pre      <= '0;
            spin_idx <= '0;
            tick_cnt <= '0;
            secs     <= '0;
        end else if (state == RUN) begin
            pre <= pre + SPIN_DIV'(1);
            if (&pre) spin_idx <= (spin_idx == 3'd5) ? 3'd0 : spin_idx + 3'd1;
            if (tick_cnt == TICK_W'(TICK_CYCLES - 1)) begin
                tick_cnt <= '0;
                if (!(&secs)) secs <= secs + SEC_W'(1);
            end else begin
                tick_cnt <= tick_cnt + TICK_W'(1);
            end
        end
    end

    always_comb begin
        for (int n = 0; n < 6; n++) begin
            hex_nxt[n] = 7'h7F;
            case (state)
                RUN:     hex_nxt[n] = ~(7'h01 << spin_idx);
                SHOW:    hex_nxt[n] = valid_q ? hex_glyph(key_q[4*n +: 4]) : 7'h3F;
                default: hex_nxt[n] = 7'h7F;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            for (int n = 0; n < 6; n++) hex_q[n] <= 7'h7F;
            ledr_q <= '0;
        end else begin
            for (int n = 0; n < 6; n++) hex_q[n] <= hex_nxt[n];
            ledr_q <= 10'(secs);
        end
    end

    assign HEX0 = hex_q[0];
    assign HEX1 = hex_q[1];
    assign HEX2 = hex_q[2];
    assign HEX3 = hex_q[3];
    assign HEX4 = hex_q[4];
    assign HEX5 = hex_q[5];
    assign LEDR = ledr_q;

endmodule

// File: tb/tb_crack_result_display.sv
// Bench for crack_result_display: engine model driven from tasks, results compared against a table-based model.
module tb_crack_result_display;
    localparam int SPIN_DIV    = 2;
    localparam int TICK_CYCLES = 10;
    localparam int SEC_W       = 10;
    localparam int SPIN_PERIOD = 1 << SPIN_DIV;
    localparam int SEC_MAX     = (1 << SEC_W) - 1;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        start = 1'b0;
    logic        crk_rdy = 1'b1;
    logic        crk_en;
    logic [23:0] key = '0;
    logic        key_valid = 1'b0;
    logic        busy;
    logic [6:0]  HEX0, HEX1, HEX2, HEX3, HEX4, HEX5;
    logic [9:0]  LEDR;
    logic [6:0]  hex [6];

    int checks = 0;
    int passes = 0;
    int en_count = 0;

    logic [6:0] glyph_tab [16] = '{7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
                                   7'h00, 7'h10, 7'h08, 7'h03, 7'h46, 7'h21, 7'h06, 7'h0E};
    // Segments a..f lit one at a time, active low.
    logic [6:0] spin_tab [6] = '{7'h7E, 7'h7D, 7'h7B, 7'h77, 7'h6F, 7'h5F};

    crack_result_display #(
        .SPIN_DIV(SPIN_DIV), .TICK_CYCLES(TICK_CYCLES), .SEC_W(SEC_W)
    ) dut (
        .clk(clk), .rst_n(rst_n), .start(start), .crk_rdy(crk_rdy), .crk_en(crk_en),
        .key(key), .key_valid(key_valid), .busy(busy),
        .HEX0(HEX0), .HEX1(HEX1), .HEX2(HEX2), .HEX3(HEX3), .HEX4(HEX4), .HEX5(HEX5),
        .LEDR(LEDR)
    );

    assign hex[0] = HEX0;
    assign hex[1] = HEX1;
    assign hex[2] = HEX2;
    assign hex[3] = HEX3;
    assign hex[4] = HEX4;
    assign hex[5] = HEX5;

    always #5 clk = ~clk;

    always @(posedge clk) if (crk_en === 1'b1) en_count <= en_count + 1;

    task automatic test_reset();
        rst_n = 1'b0;
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        repeat (20) @(negedge clk);
        for (int n = 0; n < 6; n++) begin
            checks++;
            if (hex[n] !== 7'h7F) $display("FAIL reset_hex%0d: got %h want 7f", n, hex[n]);
            else passes++;
        end
        checks++;
        if (LEDR !== 10'd0) $display("FAIL reset_ledr: got %0d want 0", LEDR); else passes++;
        checks++;
        if (crk_en !== 1'b0) $display("FAIL reset_en: got %b want 0", crk_en); else passes++;
        checks++;
        if (busy !== 1'b0) $display("FAIL reset_busy: got %b want 0", busy); else passes++;
    endtask

    // Full run from IDLE/SHOW: engine keeps rdy through the first RUN cycle, then holds it low 'hold' cycles.
    task automatic do_run(input int hold, input logic [23:0] k_in, input logic v_in,
                          input bit keep_start, input bit spin_chk, input bit led_chk, input string tag);
        int en0;
        int k;
        int idx;
        int exp_s;
        int diff;
        logic [6:0] exp_h;
        en0 = en_count;
        @(negedge clk);
        start = 1'b1;
        crk_rdy = 1'b1;
        #1;
        checks++;
        if (crk_en !== 1'b0) $display("FAIL %s en_with_start: got %b want 0", tag, crk_en); else passes++;
        @(negedge clk);
        if (!keep_start) start = 1'b0;
        checks++;
        if (crk_en !== 1'b1 || busy !== 1'b1)
            $display("FAIL %s launch_en_busy: got %b%b want 11", tag, crk_en, busy);
        else passes++;
        @(negedge clk);
        checks++;
        if (crk_en !== 1'b0 || busy !== 1'b1)
            $display("FAIL %s run_en_busy: got %b%b want 01", tag, crk_en, busy);
        else passes++;
        @(negedge clk);
        crk_rdy = 1'b0;
        key = 24'($urandom);
        key_valid = 1'($urandom_range(0, 1));
        for (int c = 1; c <= hold; c++) begin
            @(negedge clk);
            k = c + 1;
            if (spin_chk && (k % SPIN_PERIOD) == 2) begin
                idx = ((k - 1) / SPIN_PERIOD) % 6;
                for (int n = 0; n < 6; n++) begin
                    checks++;
                    if (hex[n] !== spin_tab[idx])
                        $display("FAIL %s spin_k%0d_hex%0d: got %h want %h", tag, k, n, hex[n], spin_tab[idx]);
                    else passes++;
                end
            end
        end
        key = k_in;
        key_valid = v_in;
        crk_rdy = 1'b1;
        start = 1'b0;
        @(negedge clk);
        checks++;
        if (busy !== 1'b0) $display("FAIL %s show_busy: got %b want 0", tag, busy); else passes++;
        key = 24'($urandom);
        key_valid = 1'($urandom_range(0, 1));
        @(negedge clk);
        for (int n = 0; n < 6; n++) begin
            exp_h = v_in ? glyph_tab[k_in[4*n +: 4]] : 7'h3F;
            checks++;
            if (hex[n] !== exp_h) $display("FAIL %s show_hex%0d: got %h want %h", tag, n, hex[n], exp_h);
            else passes++;
        end
        if (led_chk) begin
            exp_s = (hold + 2) / TICK_CYCLES;
            if (exp_s > SEC_MAX) exp_s = SEC_MAX;
            diff = int'(LEDR) - exp_s;
            checks++;
            if (diff > 1 || diff < -1) $display("FAIL %s ledr: got %0d want %0d(+-1)", tag, LEDR, exp_s);
            else passes++;
        end
        checks++;
        if (en_count - en0 != 1) $display("FAIL %s en_pulses: got %0d want 1", tag, en_count - en0);
        else passes++;
    endtask

    task automatic test_known_key();
        do_run(95, 24'h1A2B3C, 1'b1, 1'b0, 1'b0, 1'b1, "known_key");
    endtask

    task automatic test_invalid_key();
        do_run(95, 24'h1A2B3C, 1'b0, 1'b0, 1'b0, 1'b1, "invalid_key");
    endtask

    task automatic test_spinner();
        do_run(40, 24'($urandom), 1'b1, 1'b0, 1'b1, 1'b1, "spinner");
    endtask

    task automatic test_random_runs();
        for (int r = 0; r < 4; r++)
            do_run(int'($urandom_range(20, 150)), 24'($urandom), 1'($urandom_range(0, 1)),
                   1'b0, 1'b1, 1'b1, "random");
    endtask

    task automatic test_saturation();
        do_run(20000, 24'hABCDEF, 1'b1, 1'b0, 1'b0, 1'b0, "saturate");
        checks++;
        if (LEDR !== 10'd1023) $display("FAIL saturate_ledr: got %0d want 1023", LEDR); else passes++;
    endtask

    task automatic test_start_held();
        do_run(50, 24'h0F00D5, 1'b1, 1'b1, 1'b0, 1'b1, "start_held");
    endtask

    task automatic test_back_to_back();
        int en0;
        en0 = en_count;
        @(negedge clk);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        checks++;
        if (crk_en !== 1'b1) $display("FAIL b2b_launch_en: got %b want 1", crk_en); else passes++;
        @(negedge clk);
        @(negedge clk);
        checks++;
        if (LEDR !== 10'd0) $display("FAIL b2b_ledr_clear: got %0d want 0", LEDR); else passes++;
        for (int n = 0; n < 6; n++) begin
            checks++;
            if (hex[n] !== spin_tab[0]) $display("FAIL b2b_spin_hex%0d: got %h want %h", n, hex[n], spin_tab[0]);
            else passes++;
        end
        crk_rdy = 1'b0;
        repeat (7) @(negedge clk);
        rst_n = 1'b0;
        @(negedge clk);
        for (int n = 0; n < 6; n++) begin
            checks++;
            if (hex[n] !== 7'h7F) $display("FAIL midrun_reset_hex%0d: got %h want 7f", n, hex[n]);
            else passes++;
        end
        checks++;
        if (busy !== 1'b0 || crk_en !== 1'b0 || LEDR !== 10'd0)
            $display("FAIL midrun_reset_outs: got busy=%b en=%b ledr=%0d want 0,0,0", busy, crk_en, LEDR);
        else passes++;
        rst_n = 1'b1;
        crk_rdy = 1'b1;
        repeat (5) @(negedge clk);
        checks++;
        if (busy !== 1'b0 || hex[0] !== 7'h7F || en_count - en0 != 1)
            $display("FAIL post_reset_idle: got busy=%b hex0=%h en=%0d want 0,7f,1", busy, hex[0], en_count - en0);
        else passes++;
    endtask

    initial begin
        test_reset();
        test_known_key();
        test_invalid_key();
        test_spinner();
        test_random_runs();
        test_saturation();
        test_start_held();
        test_back_to_back();
        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end
endmodule
